// File: rtl/compare_collector_pkg.sv
// Shared definitions for the comparison result collector and the comparator side:
// FSM states, register map, iMode codes and the result classifier.
package compare_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CNT_A  = 2'd2;
  localparam logic [1:0] ADDR_CNT_B  = 2'd3;

  localparam logic [2:0] MODE_NONE   = 3'b000;
  localparam logic [2:0] MODE_X_LT_Y = 3'b010;
  localparam logic [2:0] MODE_Y_LT_X = 3'b001;
  localparam logic [2:0] MODE_EQUAL  = 3'b011;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef struct packed {
    logic x_lt_y;
    logic y_lt_x;
    logic equal;
  } hit_t;

  // Any nonzero code that is not one of the two ordering codes counts as equal.
  function automatic hit_t classify_mode(input logic [2:0] mode);
    hit_t hit;
    hit.x_lt_y = (mode == MODE_X_LT_Y);
    hit.y_lt_x = (mode == MODE_Y_LT_X);
    hit.equal  = (mode != MODE_NONE) && !hit.x_lt_y && !hit.y_lt_x;
    return hit;
  endfunction

endpackage

// File: rtl/compare_result_collector_sat_counter.sv
// Saturating event counter: clear beats increment, and the count sticks at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/compare_result_collector.sv
// Avalon-MM slave that runs comparator passes, records the outcome of each pass
// and keeps saturating per-outcome event counters.
module compare_result_collector
  import compare_collector_pkg::*;
#(
  parameter int TIMEOUT = 128,
  parameter int CW      = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic [2:0]  iMode,
  output logic        oCmpEnable,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        oIrq
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          cmp_enable;

  logic          ctrl_cont;
  logic          ctrl_irq_en;
  logic          stat_done;
  logic          stat_timeout;
  logic [1:0]    last_mode;
  logic          irq;
  logic [31:0]   readdata;

  logic          wr_ctrl;
  logic          wr_status;
  logic          start_req;
  logic          clr_counters;
  logic          result_hit;
  logic          timeout_hit;
  hit_t          mode_hit;
  logic          busy;

  logic [CW-1:0] cnt_x_lt_y;
  logic [CW-1:0] cnt_y_lt_x;
  logic [CW-1:0] cnt_equal;
  logic [CW-1:0] cnt_timeout;

  logic          unused_writedata;

  assign unused_writedata = ^avs_writedata[31:3];

  always_comb begin
    wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
    wr_status    = avs_write && (avs_address == ADDR_STATUS);
    clr_counters = avs_write && (avs_address == ADDR_CNT_B);
    start_req    = wr_ctrl && avs_writedata[CTRL_START];
    mode_hit     = classify_mode(iMode);
    result_hit   = (state == ST_WAIT) && (iMode != MODE_NONE);
    timeout_hit  = (state == ST_WAIT) && (iMode == MODE_NONE) && (wait_cnt == WAIT_LAST);
    busy         = (state != ST_IDLE);
  end

  // Pass sequencer; the comparator enable is registered alongside the state so it is high exactly in WAIT.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      cmp_enable <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state      <= ST_WAIT;
            wait_cnt   <= '0;
            cmp_enable <= 1'b1;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + WW'(1);
          if (result_hit || timeout_hit) begin
            state      <= ST_DONE;
            cmp_enable <= 1'b0;
          end
        end
        ST_DONE: begin
          if (ctrl_cont) begin
            state      <= ST_WAIT;
            wait_cnt   <= '0;
            cmp_enable <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          cmp_enable <= 1'b0;
        end
      endcase
    end
  end

  // A flag being set in the same cycle as its W1C wins, so software never loses an event.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      ctrl_cont    <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      stat_done    <= 1'b0;
      stat_timeout <= 1'b0;
      last_mode    <= 2'b00;
      irq          <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_cont   <= avs_writedata[CTRL_CONT];
        ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN];
      end

      if (result_hit) begin
        stat_done <= 1'b1;
      end else if (wr_status && avs_writedata[STAT_DONE]) begin
        stat_done <= 1'b0;
      end

      if (timeout_hit) begin
        stat_timeout <= 1'b1;
      end else if (wr_status && avs_writedata[STAT_TIMEOUT]) begin
        stat_timeout <= 1'b0;
      end

      if (result_hit) begin
        last_mode <= iMode[1:0];
      end else if (timeout_hit) begin
        last_mode <= 2'b00;
      end

      irq <= ctrl_irq_en && (stat_done || stat_timeout);
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:   readdata <= {29'd0, ctrl_irq_en, ctrl_cont, 1'b0};
        ADDR_STATUS: readdata <= {27'd0, last_mode, stat_timeout, stat_done, busy};
        ADDR_CNT_A:  readdata <= {16'(cnt_y_lt_x), 16'(cnt_x_lt_y)};
        ADDR_CNT_B:  readdata <= {16'(cnt_timeout), 16'(cnt_equal)};
        default:     readdata <= '0;
      endcase
    end
  end

  sat_counter #(.CW(CW)) u_cnt_x_lt_y (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (result_hit && mode_hit.x_lt_y),
    .clr   (clr_counters),
    .count (cnt_x_lt_y)
  );

  sat_counter #(.CW(CW)) u_cnt_y_lt_x (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (result_hit && mode_hit.y_lt_x),
    .clr   (clr_counters),
    .count (cnt_y_lt_x)
  );

  sat_counter #(.CW(CW)) u_cnt_equal (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (result_hit && mode_hit.equal),
    .clr   (clr_counters),
    .count (cnt_equal)
  );

  sat_counter #(.CW(CW)) u_cnt_timeout (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (timeout_hit),
    .clr   (clr_counters),
    .count (cnt_timeout)
  );

  assign oCmpEnable   = cmp_enable;
  assign oIrq         = irq;
  assign avs_readdata = readdata;

endmodule

// File: tb/tb_compare_result_collector.sv
// Scoreboard bench for compare_result_collector: expected register values are queued
// as each scenario is driven and checked as the bus reads come back.
module tb_compare_result_collector;
  import compare_collector_pkg::*;

  localparam int TIMEOUT = 128;
  localparam int CW      = 8;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic [2:0]  iMode = MODE_NONE;
  logic        oCmpEnable;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic        oIrq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  addr;
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t expQ[$];

  compare_result_collector #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iMode         (iMode),
    .oCmpEnable    (oCmpEnable),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .oIrq          (oIrq)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // Bus tasks are entered on a falling edge and return on the next one.
  task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge iClk);
    avs_write     = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge iClk);
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic pushExpect(input logic [1:0] addr, input string tag, input logic [31:0] value);
    exp_t e;
    e.addr  = addr;
    e.tag   = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic drainScoreboard();
    exp_t        e;
    logic [31:0] d;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      busRead(e.addr, d);
      checkOutput(e.tag, d, e.value);
    end
  endtask

  // Called on a falling edge inside WAIT: idles for 'delay' cycles, then presents one result.
  task automatic applyStimulus(input logic [2:0] mode, input int delay);
    tick(delay);
    iMode = mode;
    @(negedge iClk);
    iMode = MODE_NONE;
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          waitCycles;
    logic [31:0] held;

    // reset state
    @(negedge iClk);
    checkOutput("rst enable", {31'd0, oCmpEnable}, 32'd0);
    checkOutput("rst irq", {31'd0, oIrq}, 32'd0);
    checkOutput("rst readdata", avs_readdata, 32'd0);
    iReset_n = 1'b1;
    tick(1);
    pushExpect(ADDR_CTRL,   "rst ctrl",   32'h0);
    pushExpect(ADDR_STATUS, "rst status", 32'h0);
    pushExpect(ADDR_CNT_A,  "rst cnt_a",  32'h0);
    pushExpect(ADDR_CNT_B,  "rst cnt_b",  32'h0);
    drainScoreboard();

    // X<Y result on WAIT cycle 65 with interrupt enabled
    busWrite(ADDR_CTRL, 32'h5);
    checkOutput("xy enable on", {31'd0, oCmpEnable}, 32'd1);
    applyStimulus(MODE_X_LT_Y, 64);
    checkOutput("xy enable done", {31'd0, oCmpEnable}, 32'd0);
    checkOutput("xy irq early", {31'd0, oIrq}, 32'd0);
    tick(1);
    checkOutput("xy enable idle", {31'd0, oCmpEnable}, 32'd0);
    checkOutput("xy irq", {31'd0, oIrq}, 32'd1);
    pushExpect(ADDR_STATUS, "xy status", 32'h12);
    pushExpect(ADDR_CNT_B,  "xy cnt_b",  32'h0);
    pushExpect(ADDR_CNT_A,  "xy cnt_a",  32'h1);
    drainScoreboard();
    tick(2);
    checkOutput("readdata hold", avs_readdata, 32'h1);
    busWrite(ADDR_STATUS, 32'h2);
    tick(1);
    checkOutput("irq cleared", {31'd0, oIrq}, 32'd0);

    // timeout pass, with a stray START mid-pass that must be ignored
    busWrite(ADDR_CTRL, 32'h1);
    waitCycles = 0;
    for (int i = 0; i < 300; i++) begin
      if (!oCmpEnable) break;
      waitCycles++;
      if (i == 8) begin
        avs_address   = ADDR_CTRL;
        avs_writedata = 32'h1;
        avs_write     = 1'b1;
      end else if (i == 9) begin
        avs_write = 1'b0;
      end
      @(negedge iClk);
    end
    checkOutput("to wait cycles", waitCycles, TIMEOUT);
    tick(1);
    checkOutput("to irq off", {31'd0, oIrq}, 32'd0);
    pushExpect(ADDR_STATUS, "to status", 32'h04);
    pushExpect(ADDR_CNT_B,  "to cnt_b",  32'h0001_0000);
    pushExpect(ADDR_CNT_A,  "to cnt_a",  32'h1);
    drainScoreboard();
    busWrite(ADDR_STATUS, 32'h4);

    // continuous Y<X passes, CONT dropped during the third
    busWrite(ADDR_CNT_B, 32'h0);
    busWrite(ADDR_CTRL, 32'h3);
    applyStimulus(MODE_Y_LT_X, 3);
    checkOutput("cont gap1", {31'd0, oCmpEnable}, 32'd0);
    tick(1);
    checkOutput("cont resume1", {31'd0, oCmpEnable}, 32'd1);
    applyStimulus(MODE_Y_LT_X, 5);
    checkOutput("cont gap2", {31'd0, oCmpEnable}, 32'd0);
    tick(1);
    checkOutput("cont resume2", {31'd0, oCmpEnable}, 32'd1);
    busWrite(ADDR_CTRL, 32'h0);
    applyStimulus(MODE_Y_LT_X, 2);
    checkOutput("cont last done", {31'd0, oCmpEnable}, 32'd0);
    tick(1);
    checkOutput("cont stop1", {31'd0, oCmpEnable}, 32'd0);
    tick(1);
    checkOutput("cont stop2", {31'd0, oCmpEnable}, 32'd0);
    pushExpect(ADDR_STATUS, "cont status", 32'h0A);
    pushExpect(ADDR_CNT_A,  "cont cnt_a",  32'h0003_0000);
    drainScoreboard();

    // reset dropped at WAIT cycle 30
    busWrite(ADDR_CTRL, 32'h5);
    tick(29);
    #1 iReset_n = 1'b0;
    #1;
    checkOutput("arst enable", {31'd0, oCmpEnable}, 32'd0);
    checkOutput("arst irq", {31'd0, oIrq}, 32'd0);
    checkOutput("arst readdata", avs_readdata, 32'd0);
    @(negedge iClk);
    iReset_n = 1'b1;
    tick(1);
    pushExpect(ADDR_CTRL,   "arst ctrl",   32'h0);
    pushExpect(ADDR_STATUS, "arst status", 32'h0);
    pushExpect(ADDR_CNT_A,  "arst cnt_a",  32'h0);
    pushExpect(ADDR_CNT_B,  "arst cnt_b",  32'h0);
    drainScoreboard();
    busWrite(ADDR_CTRL, 32'h5);
    checkOutput("arst again enable", {31'd0, oCmpEnable}, 32'd1);
    applyStimulus(MODE_X_LT_Y, 64);
    tick(1);
    checkOutput("arst again irq", {31'd0, oIrq}, 32'd1);
    pushExpect(ADDR_STATUS, "arst again status", 32'h12);
    pushExpect(ADDR_CNT_A,  "arst again cnt_a",  32'h1);
    drainScoreboard();

    // saturation: roughly 300 back-to-back equal passes into an 8-bit counter
    busWrite(ADDR_STATUS, 32'h6);
    busWrite(ADDR_CNT_B, 32'h0);
    iMode = MODE_EQUAL;
    busWrite(ADDR_CTRL, 32'h3);
    tick(600);
    busWrite(ADDR_CTRL, 32'h0);
    tick(3);
    iMode = MODE_NONE;
    tick(2);
    checkOutput("sat idle", {31'd0, oCmpEnable}, 32'd0);
    pushExpect(ADDR_CNT_B, "sat cnt_b", 32'h0000_00FF);
    pushExpect(ADDR_CNT_A, "sat cnt_a", 32'h0);
    drainScoreboard();

    // W1C of DONE in the very cycle DONE is set
    busWrite(ADDR_STATUS, 32'h6);
    busWrite(ADDR_CTRL, 32'h1);
    tick(3);
    iMode         = MODE_X_LT_Y;
    avs_address   = ADDR_STATUS;
    avs_writedata = 32'h2;
    avs_write     = 1'b1;
    @(negedge iClk);
    avs_write = 1'b0;
    iMode     = MODE_NONE;
    tick(2);
    pushExpect(ADDR_STATUS, "w1c race status", 32'h12);
    drainScoreboard();

    // counter clear in the very cycle a counter increments
    busWrite(ADDR_CTRL, 32'h1);
    tick(2);
    iMode         = MODE_Y_LT_X;
    avs_address   = ADDR_CNT_B;
    avs_writedata = 32'h0;
    avs_write     = 1'b1;
    @(negedge iClk);
    avs_write = 1'b0;
    iMode     = MODE_NONE;
    tick(2);
    pushExpect(ADDR_CNT_A, "clr race cnt_a", 32'h0);
    pushExpect(ADDR_CNT_B, "clr race cnt_b", 32'h0);
    drainScoreboard();

    held = avs_readdata;
    $display("[TB] last readdata %h", held);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compare_result_collector.md
COMPARE_RESULT_COLLECTOR -- requirements
Module: compare_result_collector

Interface
REQ-001 Parameter TIMEOUT, default 128: maximum number of cycles one comparison pass waits for a result.
REQ-002 Parameter CW, default 16: width of each event counter.
REQ-003 iClk  input  1  single clock; all logic is on its rising edge.
REQ-004 iReset_n  input  1  reset, asynchronous and active-low.
REQ-005 iMode  input  3  comparator result: 3'b010 = X<Y, 3'b001 = Y<X, 3'b011 = equal, 3'b000 = no result yet.
REQ-006 oCmpEnable  output  1  enable to the upstream comparator; low restarts its step counter.
REQ-007 avs_address  input  2  Avalon-MM word address.
REQ-008 avs_read / avs_write  input  1 each  Avalon-MM strobes; never asserted together.
REQ-009 avs_writedata  input  32  write data.
REQ-010 avs_readdata  output  32  read data, registered.
REQ-011 oIrq  output  1  level interrupt to the HPS.

Function
REQ-012 Register 0 CTRL (RW) SHALL use these bits: bit0 START (write-1 pulse, reads 0), bit1 CONT, bit2 IRQ_EN.
REQ-013 Register 1 STATUS SHALL use these bits: bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bits[4:3] LAST_MODE. Writing 1 to bit1 or bit2 clears that bit (W1C).
REQ-014 Register 2 CNT_A (RO) SHALL hold the X<Y count in [15:0] and the Y<X count in [31:16].
REQ-015 Register 3 CNT_B SHALL hold the equal count in [15:0] and the timeout count in [31:16]. Any write to register 3 clears all four counters.
REQ-016 avs_readdata SHALL update one cycle after avs_read and hold its value otherwise. There are no wait states.
REQ-017 The FSM SHALL have exactly three states: IDLE, WAIT and DONE. oCmpEnable SHALL be 1 only in WAIT.
REQ-018 IDLE SHALL go to WAIT when START is written, clearing the wait counter. A START written outside IDLE SHALL be ignored.
REQ-019 In WAIT the wait counter SHALL increment every cycle.
REQ-020 In WAIT, iMode != 0 SHALL latch LAST_MODE = iMode[1:0], increment the matching counter, set DONE and go to DONE.
REQ-021 In WAIT, reaching wait counter == TIMEOUT-1 with iMode == 0 SHALL set TIMEOUT, set LAST_MODE = 0, increment the timeout count and go to DONE.
REQ-022 Any nonzero iMode other than 010 or 001 SHALL count as equal.
REQ-023 DONE SHALL last exactly one cycle with oCmpEnable = 0, then go to WAIT if CONT = 1, otherwise to IDLE.
REQ-024 BUSY SHALL be 1 whenever the state is not IDLE.
REQ-025 Counters SHALL saturate at 2^CW-1 and never wrap.
REQ-026 A counter clear written in the same cycle as an increment SHALL win, leaving 0.
REQ-027 A W1C in the same cycle as DONE or TIMEOUT being set SHALL lose, so the flag stays 1.
REQ-028 oIrq SHALL be registered and equal IRQ_EN & (DONE | TIMEOUT), i.e. high one cycle after the flag sets.
REQ-029 Clearing CONT during a pass SHALL let the current pass finish, then return to IDLE.

Reset
REQ-030 While iReset_n = 0, asynchronously: state = IDLE, oCmpEnable = 0, oIrq = 0, avs_readdata = 0, and CTRL, STATUS and all counters = 0.
REQ-031 Reset asserted mid-pass SHALL discard the pass and increment no counter.

Structure
REQ-032 Package compare_collector_pkg SHALL hold the FSM state enum, the register address constants and the iMode code constants; the comparator side shares the iMode constants.
REQ-033 One sub-module, sat_counter (CW-bit, with increment, clear and saturate), SHALL be instantiated four times.

Verification
REQ-034 Write CTRL=0x5, then drive iMode=010 on WAIT cycle 65 -> DONE=1, LAST_MODE=2'b10, CNT_A=0x00000001, oIrq high next cycle, oCmpEnable low for 1 cycle then stays low.
REQ-035 Write CTRL=0x1 with iMode held at 0 -> TIMEOUT=1 after 128 WAIT cycles, CNT_B=0x00010000, state returns to IDLE.
REQ-036 Write CTRL=0x3, give three passes with iMode=001, then write CTRL=0 -> CNT_A=0x00030000, exactly one low oCmpEnable cycle between passes, IDLE after the third pass.
REQ-037 Drive 70000 passes with iMode=011 -> CNT_B[15:0]=0xFFFF, no wrap.
REQ-038 Write W1C to DONE in the result cycle -> DONE stays 1. Write register 3 in an increment cycle -> all counters read 0.
REQ-039 Drop iReset_n in WAIT at cycle 30 -> oCmpEnable 0 without waiting for a clock edge, all registers 0, and the next START behaves as in REQ-034.
